// File: rtl/ws_pkg.sv
// ws_pkg: state encodings, timing defaults and helpers shared by the GRB transmitter and receiver
package ws_pkg;

  // Receiver line-decoder states
  typedef enum logic [1:0] {
    SWAITRST = 2'd0,
    SREADY   = 2'd1,
    SHIGH    = 2'd2,
    SLOW     = 2'd3
  } ws_state_e;

  // Default timing at 50 MHz
  localparam int HI_THRESH_DEF    = 30;
  localparam int MIN_HI_DEF       = 5;
  localparam int MAX_HI_DEF       = 75;
  localparam int RESET_CYCLES_DEF = 2500;

  localparam int CNT_W  = 12;
  localparam int WORD_W = 24;
  localparam int BIT_W  = 5;
  localparam int PIX_W  = 3;

  // Word counter that sticks at its maximum instead of wrapping
  function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] v);
    return (v == {PIX_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ws_sync.sv
// ws_sync: two-flop synchronizer for the serial line plus rise/fall detection
module ws_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic ds,
  output logic rise,
  output logic fall
);

  logic s1;
  logic ds_q;

  // Synchronizer chain followed by one delayed copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      ds   <= 1'b0;
      ds_q <= 1'b0;
    end else begin
      s1   <= din;
      ds   <= s1;
      ds_q <= ds;
    end
  end

  assign rise = ds & ~ds_q;
  assign fall = ~ds & ds_q;

endmodule

// File: rtl/grb_receiver.sv
// grb_receiver: decodes a single-wire GRB pulse-width stream into 24-bit words with frame framing
module grb_receiver
  import ws_pkg::*;
#(
  parameter int HI_THRESH    = HI_THRESH_DEF,
  parameter int MIN_HI       = MIN_HI_DEF,
  parameter int MAX_HI       = MAX_HI_DEF,
  parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic [WORD_W-1:0] grb,
  output logic              grbValid,
  output logic [PIX_W-1:0]  pixIdx,
  output logic              frameDone,
  output logic              err
);

  localparam logic [CNT_W-1:0] HI_C  = CNT_W'(HI_THRESH);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_HI);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HI);
  localparam logic [CNT_W-1:0] RST_C = CNT_W'(RESET_CYCLES);

  logic ds;
  logic rise;
  logic fall;

  ws_state_e          state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n, inc;
  logic [WORD_W-1:0]  sh, sh_n, grb_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic [PIX_W-1:0]   wcnt, wc_n, pix_n;
  logic               valid_n, fd_n, err_n;
  logic               bit_v;
  logic               drop;

  ws_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .ds   (ds),
    .rise (rise),
    .fall (fall)
  );

  // inc is the high-pulse length at a falling edge; a pulse still high
  // has reached inc+1 cycles
  always_comb begin
    inc     = cnt + 1'b1;
    bit_v   = inc >= HI_C;
    state_n = state;
    cnt_n   = inc;
    sh_n    = sh;
    bit_n   = bit_cnt;
    wc_n    = wcnt;
    grb_n   = grb;
    pix_n   = pixIdx;
    valid_n = 1'b0;
    fd_n    = 1'b0;
    err_n   = 1'b0;
    drop    = 1'b0;
    case (state)
      SWAITRST: begin
        if (ds) cnt_n = '0;
        else if (inc == RST_C) state_n = SREADY;
      end
      SREADY: begin
        cnt_n = '0;
        if (rise) state_n = SHIGH;
      end
      SHIGH: begin
        if (fall) begin
          if (inc < MIN_C) begin
            err_n   = 1'b1;
            drop    = 1'b1;
            state_n = SWAITRST;
          end else begin
            state_n = SLOW;
            sh_n    = {sh[WORD_W-2:0], bit_v};
            if (bit_cnt == BIT_W'(WORD_W - 1)) begin
              grb_n   = {sh[WORD_W-2:0], bit_v};
              valid_n = 1'b1;
              bit_n   = '0;
              pix_n   = wcnt;
              wc_n    = sat_inc(wcnt);
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end
        end else if (inc + 1'b1 == MAX_C) begin
          err_n   = 1'b1;
          drop    = 1'b1;
          state_n = SWAITRST;
        end
      end
      SLOW: begin
        if (rise) begin
          state_n = SHIGH;
        end else if (inc == RST_C) begin
          state_n = SREADY;
          fd_n    = (bit_cnt == '0) && (wcnt != '0);
          err_n   = bit_cnt != '0;
          drop    = 1'b1;
        end
      end
      default: state_n = SWAITRST;
    endcase
    if (drop) begin
      sh_n  = '0;
      bit_n = '0;
      wc_n  = '0;
    end
    if (state_n != state) cnt_n = '0;
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SWAITRST;
      cnt       <= '0;
      sh        <= '0;
      bit_cnt   <= '0;
      wcnt      <= '0;
      grb       <= '0;
      pixIdx    <= '0;
      grbValid  <= 1'b0;
      frameDone <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      bit_cnt   <= bit_n;
      wcnt      <= wc_n;
      grb       <= grb_n;
      pixIdx    <= pix_n;
      grbValid  <= valid_n;
      frameDone <= fd_n;
      err       <= err_n;
    end
  end

endmodule

// File: doc/grb_receiver.md
GRB_RECEIVER -- requirements
Module: grb_receiver

Interface
REQ-001 Parameter HI_THRESH, default 30: high-pulse length in clk cycles at or above which a bit decodes as 1 (50 MHz: 0.6 us).
REQ-002 Parameter MIN_HI, default 5: high pulses shorter than this are glitches and raise err.
REQ-003 Parameter MAX_HI, default 75: a high pulse reaching this length raises err.
REQ-004 Parameter RESET_CYCLES, default 2500: low-time in cycles that marks a latch/reset gap (50 us).
REQ-005 clk  input  1  single clock; all state changes on posedge clk.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 din  input  1  asynchronous single-wire GRB serial line.
REQ-008 grb  output  24  last decoded word; [23:16]=G, [15:8]=R, [7:0]=B.
REQ-009 grbValid  output  1  one-cycle pulse when grb updates.
REQ-010 pixIdx  output  3  index within the frame of the word in grb.
REQ-011 frameDone  output  1  one-cycle pulse at a clean frame end.
REQ-012 err  output  1  one-cycle pulse on any protocol violation.

Function
REQ-013 din SHALL pass a 2-flop synchronizer; all decoding uses the synchronized signal ds and its registered copy.
REQ-014 FSM states SHALL be SWAITRST, SREADY, SHIGH and SLOW; a single 12-bit cycle counter, cleared on every state change, serves all of them.
REQ-015 SWAITRST: counter increments while ds=0 and clears while ds=1; on reaching RESET_CYCLES the FSM SHALL go to SREADY.
REQ-016 SREADY: a rising edge of ds SHALL go to SHIGH; otherwise the FSM holds indefinitely.
REQ-017 SHIGH: counter increments each cycle; on reaching MAX_HI the FSM SHALL pulse err and go to SWAITRST.
REQ-018 SHIGH falling edge with count < MIN_HI SHALL pulse err and go to SWAITRST; otherwise the bit (count >= HI_THRESH) shifts into the LSB of a 24-bit shift register, bitCnt increments, and the FSM goes to SLOW.
REQ-019 Bits SHALL be MSB-first: the first bit received lands in grb[23].
REQ-020 On the 24th bit, grb SHALL load the shift register, grbValid SHALL pulse, bitCnt SHALL return to 0, and pixIdx SHALL take the current word count; the word count then increments, saturating at 7.
REQ-021 grbValid SHALL assert in the cycle after the clk edge that samples the falling edge, which is 3 clk cycles after the din pin falls.
REQ-022 SLOW: counter increments; a rising edge SHALL go to SHIGH.
REQ-023 SLOW with count reaching RESET_CYCLES SHALL go to SREADY, clear the word count and bitCnt, and behave as follows:
- bitCnt = 0 and at least one word received: pulse frameDone.
- bitCnt != 0 (partial word): pulse err, no frameDone.
REQ-024 grb and pixIdx SHALL hold their value between grbValid pulses; err and frameDone never assert in the same cycle.
REQ-025 An error SHALL discard the partial word; words already delivered are not retracted.

Reset
REQ-026 Asserting reset low SHALL immediately force the following:
- FSM to SWAITRST.
- grb=0, pixIdx=0, grbValid=0, frameDone=0, err=0.
- Counters, shift register and synchronizer flops to 0.
REQ-027 Reset applied mid-word SHALL discard that word; after release, decoding resumes only after a full RESET_CYCLES low gap.

Structure
REQ-028 State encodings and default timing constants SHALL live in the shared package ws_pkg, which is also used by the GRB transmitter.
REQ-029 The synchronizer and edge detector SHALL be the sub-module ws_sync (outputs ds, rise, fall); the remaining logic stays in grb_receiver.

Verification
REQ-030 Bench SHALL cover these directed scenarios:
- Scenario 1, single word: 60 us low, then word 0xA55A0F (1 = 40-cycle high/22 low, 0 = 20 high/42 low), then 60 us low -> grbValid once, grb=0xA55A0F, pixIdx=0, then frameDone once.
- Scenario 2, three words: 0x000000, 0xFFFFFF, 0x123456 back-to-back, then gap -> three grbValid pulses with pixIdx 0,1,2 and matching grb, then one frameDone; a following frame restarts at pixIdx=0.
- Scenario 3, glitch: a 3-cycle high pulse inside a word -> err pulse; no grbValid until after a fresh 2500-cycle gap; the next valid word decodes correctly.
- Scenario 4, stuck high: line high for 80 cycles -> err at cycle MAX_HI, FSM in SWAITRST.
- Scenario 5, partial word: 10 bits followed by a 60 us low -> err, no frameDone, no grbValid.
- Scenario 6, reset mid-word: reset pulsed low after 12 bits -> all outputs 0; a following complete word without a preceding gap is ignored; after a gap the word decodes correctly.
